// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and restoring divide.
// One result bit per clock; results land in hi/lo and are held until the next completion.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        dz_q, dz_d;
  logic [32:0] mcand_q, mcand_d;
  // MUL: {upper[32:0], Q[31:0], q_-1}; DIV: {2'b0, rem[31:0], quo/dividend[31:0]}
  logic [65:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] upper;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    abs_a   = a[31] ? (~a + 32'd1) : a;
    abs_b   = b[31] ? (~b + 32'd1) : b;

    case (acc_q[1:0])
      2'b01:   upper = acc_q[65:33] + mcand_q;
      2'b10:   upper = acc_q[65:33] - mcand_q;
      default: upper = acc_q[65:33];
    endcase

    shifted = {acc_q[63:32], acc_q[31]};
    trial   = shifted - mcand_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = 1'b0;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          sa_d  = a[31];
          sb_d  = b[31];
          cnt_d = '0;
          if (!op) begin
            mcand_d = {a[31], a};
            acc_d   = {33'd0, b, 1'b0};
            state_d = S_MUL;
          end else if (b == 32'd0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            mcand_d = {1'b0, abs_b};
            acc_d   = {34'd0, abs_a};
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = {upper[32], upper, acc_q[32:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_DIV: begin
        if (!trial[32]) acc_d = {2'b00, trial[31:0], acc_q[30:0], 1'b1};
        else            acc_d = {2'b00, shifted[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q) begin
          hi_d = acc_q[64:33];
          lo_d = acc_q[32:1];
        end else begin
          lo_d = (sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = sa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected results come from 64-bit signed arithmetic.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] MA [8] = '{32'd7, 32'h80000000, 32'd3, 32'd0,
                                     32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFF0001};
  localparam logic [31:0] MB [8] = '{32'hFFFFFFFD, 32'h80000000, 32'd4, 32'h12345678,
                                     32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00010003};
  localparam logic [31:0] DA [9] = '{32'hFFFFFFF9, 32'h80000000, 32'd5, 32'd7, 32'hFFFFFFF9,
                                     32'd1, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
  localparam logic [31:0] DB [9] = '{32'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                     32'h7FFFFFFF, 32'd1, 32'h80000000, 32'h80000000};

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p, r;
    sx = $signed(x);
    sy = $signed(y);
    e.dz  = 1'b0;
    e.lat = 8'd34;
    if (!o) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'd0) begin
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.dz  = 1'b1;
      e.lat = 8'd1;
    end else begin
      p    = sx / sy;
      r    = sx % sy;
      e.lo = p[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Called just after a falling edge; start is sampled at the next rising edge.
  task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e = model(o, x, y);
    sb.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic collect(input bit scramble, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output int unsigned lat, output int unsigned bcnt,
                         output logic d2, output logic [31:0] h2, output logic [31:0] l2);
    lat  = 0;
    bcnt = 0;
    rh   = 'x;
    rl   = 'x;
    rdz  = 1'bx;
    for (int unsigned c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = c;
        rh  = hi;
        rl  = lo;
        rdz = div_zero;
        break;
      end
      if (scramble) begin
        start = 1'b1;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    d2 = done | div_zero;
    h2 = hi;
    l2 = lo;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #3;
    checks++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs got hi=%h lo=%h busy=%b done=%b dz=%b exp all zero",
               hi, lo, busy, done, div_zero);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mult;
    exp_t e;
    logic [31:0] rh, rl, h2, l2;
    logic rdz, d2;
    int unsigned lat, bcnt;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) issue(1'b0, MA[i], MB[i]);
      else       issue(1'b0, $urandom, $urandom);
      collect(1'b0, rh, rl, rdz, lat, bcnt, d2, h2, l2);
      e = sb.pop_front();
      checks += 6;
      if (rh !== e.hi) begin errors++; $display("FAIL mult_hi[%0d] got %h exp %h", i, rh, e.hi); end
      if (rl !== e.lo) begin errors++; $display("FAIL mult_lo[%0d] got %h exp %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin errors++; $display("FAIL mult_dz[%0d] got %b exp %b", i, rdz, e.dz); end
      if (lat != int'(e.lat)) begin errors++; $display("FAIL mult_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      if (bcnt != int'(e.lat) - 1) begin errors++; $display("FAIL mult_busy[%0d] got %0d exp %0d", i, bcnt, e.lat - 1); end
      if ({d2, h2, l2} !== {1'b0, e.hi, e.lo}) begin
        errors++;
        $display("FAIL mult_pulse_hold[%0d] got done=%b hi=%h lo=%h exp 0 %h %h", i, d2, h2, l2, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div;
    exp_t e;
    logic [31:0] rh, rl, h2, l2;
    logic rdz, d2;
    int unsigned lat, bcnt;
    for (int i = 0; i < 13; i++) begin
      if (i < 9) issue(1'b1, DA[i], DB[i]);
      else       issue(1'b1, $urandom, $urandom | 32'd1);
      collect(1'b0, rh, rl, rdz, lat, bcnt, d2, h2, l2);
      e = sb.pop_front();
      checks += 6;
      if (rh !== e.hi) begin errors++; $display("FAIL div_rem[%0d] got %h exp %h", i, rh, e.hi); end
      if (rl !== e.lo) begin errors++; $display("FAIL div_quo[%0d] got %h exp %h", i, rl, e.lo); end
      if (rdz !== e.dz) begin errors++; $display("FAIL div_dz[%0d] got %b exp %b", i, rdz, e.dz); end
      if (lat != int'(e.lat)) begin errors++; $display("FAIL div_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      if (bcnt != int'(e.lat) - 1) begin errors++; $display("FAIL div_busy[%0d] got %0d exp %0d", i, bcnt, e.lat - 1); end
      if ({d2, h2, l2} !== {1'b0, e.hi, e.lo}) begin
        errors++;
        $display("FAIL div_pulse_hold[%0d] got done=%b hi=%h lo=%h exp 0 %h %h", i, d2, h2, l2, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    logic [31:0] rh, rl, h2, l2;
    logic rdz, d2;
    int unsigned lat, bcnt;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(1'b1, 32'd5, 32'd2);
      else        issue(1'b1, 32'd5, 32'd0);
      collect(1'b0, rh, rl, rdz, lat, bcnt, d2, h2, l2);
      e = sb.pop_front();
      checks += 5;
      if ({rh, rl} !== {e.hi, e.lo}) begin
        errors++;
        $display("FAIL dz_hilo[%0d] got %h/%h exp %h/%h", i, rh, rl, e.hi, e.lo);
      end
      if (rdz !== e.dz) begin errors++; $display("FAIL dz_flag[%0d] got %b exp %b", i, rdz, e.dz); end
      if (lat != int'(e.lat)) begin errors++; $display("FAIL dz_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      if (bcnt != int'(e.lat) - 1) begin errors++; $display("FAIL dz_busy[%0d] got %0d exp %0d", i, bcnt, e.lat - 1); end
      if (d2 !== 1'b0) begin errors++; $display("FAIL dz_pulse[%0d] got %b exp 0", i, d2); end
    end
  endtask

  // Start is held high with random operands throughout each operation; it must be ignored.
  task automatic test_back_to_back;
    exp_t e;
    logic [31:0] rh, rl, h2, l2;
    logic rdz, d2;
    int unsigned lat, bcnt;
    issue(1'b1, 32'd100, 32'hFFFFFFF9);
    for (int i = 0; i < 4; i++) begin
      collect(1'b1, rh, rl, rdz, lat, bcnt, d2, h2, l2);
      e = sb.pop_front();
      if (i < 3) issue(1'(i), $urandom, $urandom | 32'd4);
      checks += 4;
      if ({rh, rl} !== {e.hi, e.lo}) begin
        errors++;
        $display("FAIL b2b_hilo[%0d] got %h/%h exp %h/%h", i, rh, rl, e.hi, e.lo);
      end
      if (lat != int'(e.lat)) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, lat, e.lat); end
      if (rdz !== e.dz) begin errors++; $display("FAIL b2b_dz[%0d] got %b exp %b", i, rdz, e.dz); end
      if (d2 !== 1'b0) begin errors++; $display("FAIL b2b_pulse[%0d] got %b exp 0", i, d2); end
    end
  endtask

  task automatic test_reset_abort;
    exp_t e;
    logic [31:0] rh, rl, h2, l2;
    logic rdz, d2;
    int unsigned lat, bcnt;
    logic saw_done;
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd3;
    b     = 32'd4;
    saw_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
      errors++;
      $display("FAIL abort_async got hi=%h lo=%h busy=%b done=%b dz=%b exp all zero",
               hi, lo, busy, done, div_zero);
    end
    @(negedge clk);
    reset   = 1'b0;
    last_hi = '0;
    last_lo = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || {hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL abort_quiet got activity=%b hi=%h lo=%h exp 0 0 0", saw_done, hi, lo);
    end
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 32'd3, 32'd4);
    collect(1'b0, rh, rl, rdz, lat, bcnt, d2, h2, l2);
    e = sb.pop_front();
    checks += 2;
    if ({rh, rl} !== {e.hi, e.lo}) begin
      errors++;
      $display("FAIL abort_rerun got %h/%h exp %h/%h", rh, rl, e.hi, e.lo);
    end
    if (lat != int'(e.lat)) begin errors++; $display("FAIL abort_rerun_latency got %0d exp %0d", lat, e.lat); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  operation select: 0 = signed MULT, 1 = signed DIV.
REQ-006 a  input  32  operand A, two's complement: multiplicand or dividend.
REQ-007 b  input  32  operand B, two's complement: multiplier or divisor.
REQ-008 hi  output  32  MULT: product[63:32]; DIV: remainder.
REQ-009 lo  output  32  MULT: product[31:0]; DIV: quotient.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when an operation completes.
REQ-012 div_zero  output  1  one-cycle pulse with done when DIV has b = 0.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX and DONE.
REQ-014 IDLE: on an edge with start = 1, latch a, b and op, then go to MUL (op = 0) or DIV (op = 1, b != 0).
REQ-015 IDLE with start = 1, op = 1, b = 0: go to DONE; assert div_zero; leave hi/lo unchanged.
REQ-016 MUL: signed radix-2 Booth, one step per cycle, 32 cycles, 64-bit accumulator, then FIX.
REQ-017 DIV: restoring division on operand magnitudes, one quotient bit per cycle, 32 cycles, then FIX.
REQ-018 FIX: negate the quotient if the operand signs differ; give the remainder the sign of the dividend; MULT passes through unchanged.
REQ-019 FIX SHALL write hi/lo and go to DONE.
REQ-020 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-021 Latency: start accepted at edge k -> hi/lo valid and done = 1 after edge k+34, for both ops.
REQ-022 Latency, divide-by-zero: done = 1 and div_zero = 1 after edge k+1.
REQ-023 busy SHALL be 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
REQ-024 start SHALL be ignored while busy = 1 or in DONE; no queuing.
REQ-025 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-026 DIV quotient SHALL truncate toward zero.
REQ-027 0x80000000 / -1: lo = 0x80000000 and hi = 0 (wrap, no flag).
REQ-028 hi/lo SHALL hold their last written value until the next successful completion.
REQ-029 Back-to-back operation: start high in the cycle after done (state IDLE) SHALL be accepted.

Reset
REQ-030 Reset asserted SHALL force IDLE, hi = 0, lo = 0, busy = 0, done = 0 and div_zero = 0, independent of clk.
REQ-031 Reset during MUL/DIV/FIX SHALL abort the operation with no done pulse and no hi/lo update.
REQ-032 The first rising edge after reset deasserts SHALL be able to accept start.

Verification
REQ-033 MULT a = 7, b = 0xFFFFFFFD (-3) -> after 34 cycles hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, done pulse 1 cycle.
REQ-034 MULT a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
REQ-035 DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), done at cycle 34.
REQ-036 DIV a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0x00000000.
REQ-037 DIV a = 5, b = 0 after a prior result hi/lo = 0x1/0x2 -> next cycle done = div_zero = 1, hi/lo still 0x1/0x2, busy never high.
REQ-038 Reset pulse at cycle 10 of MULT 3 x 4 -> hi = lo = 0, busy = 0, no done; new MULT 3 x 4 -> lo = 0xC, hi = 0.
